// File: rtl/mig_token_bucket_if.sv
// mig_token_bucket_if: config, APM, L1 enable and trigger-stream signals of the token-bucket throttle
interface mig_token_bucket_if #(
   parameter int N_CORES = 3,
   parameter int DSID_W = 2
);
   logic cfg_wr_en;
   logic [2:0] cfg_wr_core;
   logic [1:0] cfg_wr_sel;
   logic [31:0] cfg_wr_data;
   logic apm_valid;
   logic [DSID_W-1:0] apm_dsid;
   logic [15:0] apm_bytes;
   logic [N_CORES-1:0] l1enable;
   logic trigger_axis_ready;
   logic trigger_axis_valid;
   logic [15:0] trigger_axis_bits;
   modport master (
      output cfg_wr_en, cfg_wr_core, cfg_wr_sel, cfg_wr_data,
      output apm_valid, apm_dsid, apm_bytes, trigger_axis_ready,
      input l1enable, trigger_axis_valid, trigger_axis_bits
   );
   modport slave (
      input cfg_wr_en, cfg_wr_core, cfg_wr_sel, cfg_wr_data,
      input apm_valid, apm_dsid, apm_bytes, trigger_axis_ready,
      output l1enable, trigger_axis_valid, trigger_axis_bits
   );
endinterface

// File: rtl/mig_token_bucket.sv
// mig_token_bucket: per-core token-bucket bandwidth throttle driving L1 enables and a throttle-event stream
module mig_token_bucket #(
   parameter int N_CORES = 3,
   parameter int DSID_W = 2,
   parameter int TOKEN_W = 32,
   parameter int FREQ_W = 32,
   parameter logic [TOKEN_W-1:0] RESET_SIZE = 32'h0000_1000
) (
   input logic clock,
   input logic reset,
   mig_token_bucket_if.slave bus
);
   typedef enum logic {IDLE, SEND} state_t;
   logic wr_en_q;
   logic [2:0] wr_core_q;
   logic [1:0] wr_sel_q;
   logic [31:0] wr_data_q;
   logic [TOKEN_W-1:0] size_q [N_CORES], size_d [N_CORES];
   logic [TOKEN_W-1:0] tokens_q [N_CORES], tokens_d [N_CORES];
   logic [TOKEN_W-1:0] inc_q [N_CORES], inc_d [N_CORES];
   logic [FREQ_W-1:0] freq_q [N_CORES], freq_d [N_CORES];
   logic [FREQ_W-1:0] cnt_q [N_CORES], cnt_d [N_CORES];
   logic [N_CORES-1:0] l1en_q, l1en_d, pend_q, clr;
   state_t state_q, state_d;
   logic [2:0] ptr_q, ptr_d, idx_q, idx_d;
   logic valid_q, valid_d;
   logic [15:0] bits_q, bits_d;
   // refill clamps to size before consumption; config writes override the computed result
   always_comb begin : p_bkt
      logic wr, refill;
      logic [TOKEN_W:0] sum, t1;
      logic [TOKEN_W-1:0] bytes, t2, wdat;
      l1en_d = '0;
      for (int i = 0; i < N_CORES; i++) begin
         wr = wr_en_q && int'(wr_core_q) == i;
         refill = freq_q[i] != '0 && cnt_q[i] == freq_q[i] - FREQ_W'(1) && !(wr && wr_sel_q == 2'd1);
         bytes = bus.apm_valid && int'(bus.apm_dsid) == i ? TOKEN_W'(bus.apm_bytes) : '0;
         sum = {1'b0, tokens_q[i]} + {1'b0, refill ? inc_q[i] : TOKEN_W'(0)};
         t1 = sum > {1'b0, size_q[i]} ? {1'b0, size_q[i]} : sum;
         t2 = t1 > {1'b0, bytes} ? TOKEN_W'(t1 - {1'b0, bytes}) : '0;
         wdat = wr_data_q[TOKEN_W-1:0];
         size_d[i] = wr && wr_sel_q == 2'd0 ? wdat : size_q[i];
         freq_d[i] = wr && wr_sel_q == 2'd1 ? wr_data_q[FREQ_W-1:0] : freq_q[i];
         inc_d[i] = wr && wr_sel_q == 2'd2 ? wdat : inc_q[i];
         tokens_d[i] = !wr ? t2 :
                       wr_sel_q == 2'd0 ? (t2 < wdat ? t2 : wdat) :
                       wr_sel_q == 2'd3 ? (wdat < size_q[i] ? wdat : size_q[i]) : t2;
         cnt_d[i] = (wr && wr_sel_q == 2'd1) || freq_q[i] == '0 || refill ? '0 : cnt_q[i] + FREQ_W'(1);
         l1en_d[i] = freq_d[i] == '0 || tokens_d[i] != '0;
      end
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wr_en_q <= 1'b0;
         wr_core_q <= '0;
         wr_sel_q <= '0;
         wr_data_q <= '0;
         for (int i = 0; i < N_CORES; i++) begin
            size_q[i] <= RESET_SIZE;
            tokens_q[i] <= RESET_SIZE;
            inc_q[i] <= '0;
            freq_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         l1en_q <= '1;
         pend_q <= '0;
      end else begin
         wr_en_q <= bus.cfg_wr_en;
         wr_core_q <= bus.cfg_wr_core;
         wr_sel_q <= bus.cfg_wr_sel;
         wr_data_q <= bus.cfg_wr_data;
         size_q <= size_d;
         tokens_q <= tokens_d;
         inc_q <= inc_d;
         freq_q <= freq_d;
         cnt_q <= cnt_d;
         l1en_q <= l1en_d;
         pend_q <= (pend_q & ~clr) | (l1en_q & ~l1en_d);
      end
   // round-robin pick: first pending bit at or after ptr, else the first one below it
   always_comb begin : p_fsm
      logic found;
      state_d = state_q;
      ptr_d = ptr_q;
      idx_d = idx_q;
      valid_d = valid_q;
      bits_d = bits_q;
      clr = '0;
      found = 1'b0;
      if (state_q == IDLE) begin
         for (int i = 0; i < N_CORES; i++)
            if (!found && pend_q[i] && i >= int'(ptr_q)) begin
               found = 1'b1;
               idx_d = 3'(i);
            end
         for (int i = 0; i < N_CORES; i++)
            if (!found && pend_q[i]) begin
               found = 1'b1;
               idx_d = 3'(i);
            end
         for (int i = 0; i < N_CORES; i++)
            clr[i] = found && int'(idx_d) == i;
         if (found) begin
            bits_d = {8'hA5, 5'b0, idx_d};
            valid_d = 1'b1;
            state_d = SEND;
         end
      end else if (bus.trigger_axis_ready) begin
         valid_d = 1'b0;
         ptr_d = int'(idx_q) >= N_CORES - 1 ? 3'd0 : idx_q + 3'd1;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         ptr_q <= '0;
         idx_q <= '0;
         valid_q <= 1'b0;
         bits_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         valid_q <= valid_d;
         bits_q <= bits_d;
      end
   assign bus.l1enable = l1en_q;
   assign bus.trigger_axis_valid = valid_q;
   assign bus.trigger_axis_bits = bits_q;
endmodule

// File: tb/tb_mig_token_bucket.sv
// tb_mig_token_bucket: directed checks of refill, consumption, clamping, config writes and the trigger stream
module tb_mig_token_bucket;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   mig_token_bucket_if #(.N_CORES(3), .DSID_W(2)) bus ();
   mig_token_bucket dut (.clock(clock), .reset(reset), .bus(bus.slave));
   always #5 clock = ~clock;
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic cfg(input logic [2:0] core, input logic [1:0] sel, input logic [31:0] data);
      bus.cfg_wr_en = 1'b1;
      bus.cfg_wr_core = core;
      bus.cfg_wr_sel = sel;
      bus.cfg_wr_data = data;
      tick();
      bus.cfg_wr_en = 1'b0;
   endtask
   task automatic apm(input logic [1:0] dsid, input logic [15:0] bytes);
      bus.apm_valid = 1'b1;
      bus.apm_dsid = dsid;
      bus.apm_bytes = bytes;
      tick();
      bus.apm_valid = 1'b0;
   endtask
   task automatic ack();
      bus.trigger_axis_ready = 1'b1;
      tick();
      bus.trigger_axis_ready = 1'b0;
   endtask
   initial begin
      bus.cfg_wr_en = 1'b0;
      bus.cfg_wr_core = '0;
      bus.cfg_wr_sel = '0;
      bus.cfg_wr_data = '0;
      bus.apm_valid = 1'b0;
      bus.apm_dsid = '0;
      bus.apm_bytes = '0;
      bus.trigger_axis_ready = 1'b0;
      #12 reset = 1'b0;
      tick();
      chk("rst_l1enable", bus.l1enable, 3'b111);
      chk("rst_valid", bus.trigger_axis_valid, 0);
      chk("rst_bits", bus.trigger_axis_bits, 0);
      // freq==0 keeps the enable high even with an empty bucket
      apm(0, 16'h1000);
      chk("b0_disabled_en", bus.l1enable, 3'b111);
      tick();
      chk("b0_disabled_no_evt", bus.trigger_axis_valid, 0);
      cfg(0, 1, 4);
      tick();
      chk("b0_freq_throttle", bus.l1enable, 3'b110);
      chk("b0_evt_not_yet", bus.trigger_axis_valid, 0);
      tick();
      chk("b0_evt_valid", bus.trigger_axis_valid, 1);
      chk("b0_evt_bits", bus.trigger_axis_bits, 16'hA500);
      ack();
      chk("b0_evt_done", bus.trigger_axis_valid, 0);
      tick();
      chk("b0_single_evt", bus.trigger_axis_valid, 0);
      // bucket 1: size 100, inc 20 every 10 cycles, starting empty
      cfg(1, 0, 100);
      cfg(1, 2, 20);
      cfg(1, 3, 0);
      cfg(1, 1, 10);
      tick();
      chk("b1_throttled", bus.l1enable[1], 0);
      tick();
      chk("b1_evt_valid", bus.trigger_axis_valid, 1);
      chk("b1_evt_bits", bus.trigger_axis_bits, 16'hA501);
      ack();
      chk("b1_evt_done", bus.trigger_axis_valid, 0);
      repeat (7) tick();
      chk("b1_before_refill", bus.l1enable[1], 0);
      tick();
      chk("b1_first_refill", bus.l1enable[1], 1);
      repeat (51) tick();
      apm(1, 100);
      chk("b1_saturated", bus.l1enable[1], 0);
      tick();
      chk("b1_evt2_valid", bus.trigger_axis_valid, 1);
      chk("b1_evt2_bits", bus.trigger_axis_bits, 16'hA501);
      ack();
      // bucket 2: 30 + 20 clamps to 40, then 40 bytes empty it
      cfg(2, 0, 40);
      cfg(2, 2, 20);
      cfg(2, 1, 1);
      cfg(2, 3, 30);
      tick();
      apm(2, 40);
      chk("b2_clamp_consume", bus.l1enable[2], 0);
      tick();
      chk("b2_evt_valid", bus.trigger_axis_valid, 1);
      chk("b2_evt_bits", bus.trigger_axis_bits, 16'hA502);
      chk("b2_refilled", bus.l1enable[2], 1);
      ack();
      // cores 0 and 2 throttle on the same edge
      cfg(0, 3, 16);
      cfg(2, 3, 0);
      apm(0, 16);
      chk("dual_throttle", bus.l1enable, 3'b010);
      tick();
      chk("dual_first_valid", bus.trigger_axis_valid, 1);
      chk("dual_first_bits", bus.trigger_axis_bits, 16'hA500);
      repeat (4) begin
         tick();
         chk("stall_valid", bus.trigger_axis_valid, 1);
         chk("stall_bits", bus.trigger_axis_bits, 16'hA500);
      end
      ack();
      chk("dual_gap", bus.trigger_axis_valid, 0);
      tick();
      chk("dual_second_valid", bus.trigger_axis_valid, 1);
      chk("dual_second_bits", bus.trigger_axis_bits, 16'hA502);
      ack();
      chk("dual_done", bus.trigger_axis_valid, 0);
      // reset while an event is being presented
      cfg(2, 3, 0);
      tick();
      tick();
      chk("pre_rst_valid", bus.trigger_axis_valid, 1);
      chk("pre_rst_bits", bus.trigger_axis_bits, 16'hA502);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", bus.trigger_axis_valid, 0);
      chk("async_rst_bits", bus.trigger_axis_bits, 0);
      chk("async_rst_l1enable", bus.l1enable, 3'b111);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("post_rst_no_evt", bus.trigger_axis_valid, 0);
      chk("post_rst_l1enable", bus.l1enable, 3'b111);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
